// File: rtl/oram_pos_map_unit_if.sv
// Request/response handshake bundle for the ORAM position-map unit.
// master drives lookups and consumes responses; slave is the unit itself.
interface oram_pos_map_unit_if #(
  parameter int TREE_DEPTH = 14
);
  logic                  req_valid;
  logic                  req_ready;
  logic [TREE_DEPTH-1:0] req_block;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [TREE_DEPTH-2:0] rsp_old_pos;
  logic                  rsp_old_valid;
  logic [TREE_DEPTH-2:0] rsp_new_pos;

  modport master (
    output req_valid, req_block, rsp_ready,
    input  req_ready, rsp_valid, rsp_old_pos, rsp_old_valid, rsp_new_pos
  );

  modport slave (
    input  req_valid, req_block, rsp_ready,
    output req_ready, rsp_valid, rsp_old_pos, rsp_old_valid, rsp_new_pos
  );
endinterface

// File: rtl/oram_pos_map_unit.sv
// ORAM position map: block -> leaf table with random remap on every access.
// Optional ORAM_POSMAP_STATS_EN adds saturating req_count/miss_count outputs.
module oram_pos_map_unit #(
  parameter int          TREE_DEPTH = 14,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  oram_pos_map_unit_if.slave       bus,
  output logic                     init_done
`ifdef ORAM_POSMAP_STATS_EN
  ,
  output logic [31:0]              miss_count,
  output logic [31:0]              req_count
`endif
);
  localparam int PW    = TREE_DEPTH - 1;
  localparam int DEPTH = 1 << TREE_DEPTH;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [TREE_DEPTH-1:0] sweep_q, sweep_d;
  logic [TREE_DEPTH-1:0] block_q, block_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [PW-1:0]         old_pos_q, old_pos_d;
  logic [PW-1:0]         new_pos_q, new_pos_d;
  logic                  old_valid_q, old_valid_d;

  // Entry layout: {pos, empty_n}; empty_n lives in bit 0.
  logic [TREE_DEPTH-1:0] mem [DEPTH];
  logic [TREE_DEPTH-1:0] ram_rdata;
  logic [TREE_DEPTH-1:0] ram_wdata;
  logic [TREE_DEPTH-1:0] ram_addr;
  logic                  ram_we;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end else begin
      ram_rdata <= mem[ram_addr];
    end
  end

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    block_d     = block_q;
    old_pos_d   = old_pos_q;
    new_pos_d   = new_pos_q;
    old_valid_d = old_valid_q;
    ram_we      = 1'b0;
    ram_addr    = block_q;
    ram_wdata   = '0;
    case (state_q)
      S_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = sweep_q;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == {TREE_DEPTH{1'b1}}) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        // Read is launched speculatively so data is ready in S_READ.
        ram_addr = bus.req_block;
        if (bus.req_valid) begin
          block_d = bus.req_block;
          state_d = S_READ;
        end
      end
      S_READ: begin
        old_valid_d = ram_rdata[0];
        old_pos_d   = ram_rdata[0] ? ram_rdata[TREE_DEPTH-1:1] : lfsr_q[PW-1:0];
        new_pos_d   = lfsr_q[15 -: PW];
        ram_we      = 1'b1;
        ram_addr    = block_q;
        ram_wdata   = {lfsr_q[15 -: PW], 1'b1};
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      block_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      old_pos_q   <= '0;
      new_pos_q   <= '0;
      old_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      block_q     <= block_d;
      lfsr_q      <= lfsr_d;
      old_pos_q   <= old_pos_d;
      new_pos_q   <= new_pos_d;
      old_valid_q <= old_valid_d;
    end
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.rsp_valid     = (state_q == S_RESP);
  assign bus.rsp_old_pos   = old_pos_q;
  assign bus.rsp_new_pos   = new_pos_q;
  assign bus.rsp_old_valid = old_valid_q;
  assign init_done         = (state_q != S_INIT);

`ifdef ORAM_POSMAP_STATS_EN
  logic [31:0] req_cnt_q, req_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    req_cnt_d  = req_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_IDLE && bus.req_valid && req_cnt_q != 32'hFFFF_FFFF) begin
      req_cnt_d = req_cnt_q + 32'd1;
    end
    if (state_q == S_READ && !ram_rdata[0] && miss_cnt_q != 32'hFFFF_FFFF) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      req_cnt_q  <= req_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign req_count  = req_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_oram_pos_map_unit.sv
// Directed bench for oram_pos_map_unit: init sweep, remap, stall, reset in RESP,
// and 100 random lookups against an LFSR/table model. Honours ORAM_POSMAP_STATS_EN.
module tb_oram_pos_map_unit;
  localparam int TD = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;
`ifdef ORAM_POSMAP_STATS_EN
  logic [31:0] miss_count;
  logic [31:0] req_count;
`endif

  oram_pos_map_unit_if #(.TREE_DEPTH(TD)) bus ();

  oram_pos_map_unit #(.TREE_DEPTH(TD), .LFSR_SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .init_done (init_done)
`ifdef ORAM_POSMAP_STATS_EN
    ,
    .miss_count(miss_count),
    .req_count (req_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference LFSR: seed while in reset, one Galois step per clock otherwise.
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  logic [TD-2:0] pos_m    [1 << TD];
  bit            mapped_m [1 << TD];
  int checks = 0;
  int passed = 0;
  int exp_req = 0;
  int exp_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < (1 << TD); i++) begin
      mapped_m[i] = 1'b0;
      pos_m[i]    = '0;
    end
    exp_req  = 0;
    exp_miss = 0;
  endtask

  // Called right after rst_n is released at a negedge.
  task automatic init_seq();
    bit early = 1'b0;
    chk("init_ready_low", {31'd0, bus.req_ready}, 32'd0);
    for (int k = 1; k < (1 << TD); k++) begin
      @(posedge clk); #1;
      if (bus.req_ready || init_done) early = 1'b1;
    end
    chk("init_held_low_16383", {31'd0, early}, 32'd0);
    @(posedge clk); #1;
    chk("init_ready_after", {31'd0, bus.req_ready}, 32'd1);
    chk("init_done_after", {31'd0, init_done}, 32'd1);
    $display("init: sweep of %0d cycles complete", 1 << TD);
  endtask

  task automatic do_req(input int blk, input int stall);
    logic [15:0]   l;
    logic [TD-2:0] eo, en;
    logic          ev;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_block = blk[TD-1:0];
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    l  = lfsr_m;
    chk("read_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("read_req_ready", {31'd0, bus.req_ready}, 32'd0);
    ev = mapped_m[blk];
    eo = ev ? pos_m[blk] : l[TD-2:0];
    en = l[15 -: TD-1];
    @(posedge clk); #1;
    chk("rsp_valid_lat2", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rsp_old_valid", {31'd0, bus.rsp_old_valid}, {31'd0, ev});
    chk("rsp_old_pos", 32'(bus.rsp_old_pos), 32'(eo));
    chk("rsp_new_pos", 32'(bus.rsp_new_pos), 32'(en));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("stall_old_valid", {31'd0, bus.rsp_old_valid}, {31'd0, ev});
      chk("stall_old_pos", 32'(bus.rsp_old_pos), 32'(eo));
      chk("stall_new_pos", 32'(bus.rsp_new_pos), 32'(en));
      chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    exp_req++;
    if (!ev) exp_miss++;
    mapped_m[blk] = 1'b1;
    pos_m[blk]    = en;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("post_hs_req_ready", {31'd0, bus.req_ready}, 32'd1);
    $display("req blk=%0d stall=%0d old_valid=%0d old_pos=%0h new_pos=%0h",
             blk, stall, ev, eo, en);
  endtask

  initial begin
    int blk;
    bus.req_valid = 1'b0;
    bus.req_block = '0;
    bus.rsp_ready = 1'b0;
    clear_model();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_old_pos", 32'(bus.rsp_old_pos), 32'd0);
    chk("rst_new_pos", 32'(bus.rsp_new_pos), 32'd0);
    chk("rst_old_valid", {31'd0, bus.rsp_old_valid}, 32'd0);
`ifdef ORAM_POSMAP_STATS_EN
    chk("rst_req_count", req_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    init_seq();

    // First touch then remap hit on block 5, then a 10-cycle stall on block 9
    do_req(5, 0);
    do_req(5, 0);
    do_req(9, 10);

    // Reset while a response is pending
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_block = 14'd5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_resp_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_resp_old_pos", 32'(bus.rsp_old_pos), 32'd0);
    $display("reset asserted during response");
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    init_seq();
    do_req(5, 0);

    // Random lookups over a small block range so hits and misses both occur
    for (int n = 0; n < 100; n++) begin
      blk = int'($urandom_range(0, 31));
      do_req(blk, 0);
    end
`ifdef ORAM_POSMAP_STATS_EN
    chk("req_count", req_count, 32'(exp_req));
    chk("miss_count", miss_count, 32'(exp_miss));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
